uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the RV32I core's data-memory port as a write responder, alongside the data memory. Core stores to its address window push bytes into a 4-entry FIFO. A serial FSM drains the FIFO as 8N1 frames on `tx`. Core loads from the window return a status word; the top level muxes `ReadData` into `ReadDataM` when `SelM` is high.

---
 rtl/riscv_mmio_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_mmio.sv | 154 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the RV32I data port:
// register offsets, UART status bit positions and transmitter state encoding.
package riscv_mmio_pkg;

    localparam logic UART_TXDATA_OFF = 1'b0;
    localparam logic UART_STATUS_OFF = 1'b1;

    localparam int UART_STATUS_BUSY      = 0;
    localparam int UART_STATUS_FULL      = 1;
    localparam int UART_STATUS_EMPTY     = 2;
    localparam int UART_STATUS_OVERFLOW  = 3;
    localparam int UART_STATUS_COUNT_LSB = 4;
    localparam int UART_STATUS_COUNT_MSB = 6;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push into a full FIFO is
// still accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter on the core data port: stores to TXDATA queue bytes,
// loads from STATUS report busy/full/empty/overflow/count.
//   state | meaning
//   IDLE  | line high, pop next byte when FIFO non-empty
//   START | start bit (low)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (high)
module uart_tx_mmio
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic        SelM,
    output logic [31:0] ReadData,
    output logic        tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e        state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_d;
    logic               overflow_q;

    logic               wr_txdata;
    logic               wr_status;
    logic               overflow_set;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic [31:0]        status;
    logic               unused_bits;

    assign SelM         = (DataAdrM[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata    = MemWriteM && SelM && (DataAdrM[2] == UART_TXDATA_OFF);
    assign wr_status    = MemWriteM && SelM && (DataAdrM[2] == UART_STATUS_OFF);
    assign overflow_set = wr_txdata && fifo_full && !fifo_pop;
    assign unused_bits  = ^{DataAdrM[1:0], WriteDataM[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (WriteDataM[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    state_d  = UART_START;
                end
            end
            UART_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase

        // tx is registered from the next state so the line moves on the same edge as the FSM
        case (state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (wr_status && WriteDataM[UART_STATUS_OVERFLOW]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status = '0;
        status[UART_STATUS_BUSY]     = (state_q != UART_IDLE) || !fifo_empty;
        status[UART_STATUS_FULL]     = fifo_full;
        status[UART_STATUS_EMPTY]    = fifo_empty;
        status[UART_STATUS_OVERFLOW] = overflow_q;
        status[UART_STATUS_COUNT_MSB:UART_STATUS_COUNT_LSB] = 3'(fifo_count);

        ReadData = '0;
        if (SelM && (DataAdrM[2] == UART_STATUS_OFF)) begin
            ReadData = status;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random traffic, all checked
// against a frame-schedule model (start time per accepted byte).
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic        SelM;
    logic [31:0] ReadData;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .DataAdrM   (DataAdrM),
        .WriteDataM (WriteDataM),
        .SelM       (SelM),
        .ReadData   (ReadData),
        .tx         (tx)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Each accepted byte: edge it was stored, edge its start bit begins, value.
    int         m_push[$];
    int         m_start[$];
    logic [7:0] m_byte[$];
    int         last_start;
    bit         m_ovf;

    function automatic void model_reset();
        m_push.delete();
        m_start.delete();
        m_byte.delete();
        last_start = -1000;
        m_ovf      = 1'b0;
    endfunction

    function automatic logic model_tx(int c);
        foreach (m_start[i]) begin
            if (c >= m_start[i] && c < m_start[i] + FRAME) begin
                int idx;
                logic [7:0] b;
                idx = (c - m_start[i]) / CPB;
                b   = m_byte[i];
                if (idx == 0) return 1'b0;
                if (idx <= 8) return b[idx-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_status(int c);
        int cnt = 0;
        bit busy = 1'b0;
        logic [31:0] st = '0;
        foreach (m_start[i]) begin
            if (m_push[i] <= c && m_start[i] > c) cnt++;
            if (c >= m_start[i] && c < m_start[i] + FRAME) busy = 1'b1;
        end
        st[0]   = busy || (cnt > 0);
        st[1]   = (cnt == 4);
        st[2]   = (cnt == 0);
        st[3]   = m_ovf;
        st[6:4] = 3'(cnt);
        return st;
    endfunction

    function automatic void model_store(int t, logic [31:0] addr, logic [31:0] data);
        int pending = 0;
        int s;
        if ((addr >> 3) != (BASE >> 3)) return;
        if (addr[2] == 1'b0) begin
            foreach (m_start[i]) if (m_start[i] > t) pending++;
            if (pending < 4) begin
                s = (t + 1 > last_start + FRAME + 1) ? t + 1 : last_start + FRAME + 1;
                m_push.push_back(t);
                m_start.push_back(s);
                m_byte.push_back(data[7:0]);
                last_start = s;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (data[3]) begin
            m_ovf = 1'b0;
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("tx_wave", {31'b0, tx}, {31'b0, model_tx(cyc)});
    endtask

    task automatic store(logic [31:0] addr, logic [31:0] data);
        DataAdrM   = addr;
        WriteDataM = data;
        MemWriteM  = 1'b1;
        model_store(cyc + 1, addr, data);
        step();
        MemWriteM  = 1'b0;
    endtask

    task automatic read_check(string tag, logic [31:0] addr, logic [31:0] exp);
        MemWriteM = 1'b0;
        DataAdrM  = addr;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        model_reset();
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic drain();
        while (cyc <= last_start + FRAME + 1) step();
    endtask

    initial begin
        int k;
        int r;
        int gap;
        logic [31:0] addr;
        logic [31:0] data;

        reset      = 1'b1;
        MemWriteM  = 1'b0;
        DataAdrM   = 32'h0;
        WriteDataM = 32'h0;
        model_reset();

        // Reset state
        do_reset(2);
        check("reset_tx", {31'b0, tx}, 32'h1);
        read_check("reset_status", BASE + 4, 32'h4);
        read_check("reset_sel", BASE + 4, 32'h4);
        check("sel_in_window", {31'b0, SelM}, 32'h1);

        // Single byte A5: waveform checked every cycle by the model
        k = cyc + 1;
        store(BASE, 32'hA5);
        check("single_start", {31'b0, tx}, 32'h1);
        step();
        check("single_startbit", {31'b0, tx}, 32'h0);
        repeat (4) step();
        check("single_bit0", {31'b0, tx}, 32'h1);
        while (cyc < k + 41) step();
        read_check("single_done_status", BASE + 4, 32'h4);

        // Overflow: six consecutive stores
        for (int i = 0; i < 6; i++) store(BASE, 32'h10 + i);
        read_check("ovf_status", BASE + 4, 32'h4B);
        read_check("ovf_model", BASE + 4, model_status(cyc));
        store(BASE + 4, 32'h8);
        read_check("ovf_clear", BASE + 4, 32'h43);
        drain();
        read_check("ovf_drained", BASE + 4, 32'h4);

        // Back-to-back 00 then FF
        k = cyc + 1;
        store(BASE, 32'h00);
        store(BASE, 32'hFF);
        while (cyc < k + 40) step();
        check("b2b_stop_end", {31'b0, tx}, 32'h1);
        step();
        check("b2b_idle_gap", {31'b0, tx}, 32'h1);
        step();
        check("b2b_start2", {31'b0, tx}, 32'h0);
        drain();

        // Reset during the DATA phase of 0F
        k = cyc + 1;
        store(BASE, 32'h0F);
        while (cyc < k + 15) step();
        check("midrst_in_data", {31'b0, tx}, 32'h1);
        do_reset(1);
        check("midrst_tx", {31'b0, tx}, 32'h1);
        read_check("midrst_empty", BASE + 4, 32'h4);
        repeat (50) step();
        read_check("midrst_no_frame", BASE + 4, 32'h4);

        // Address decode
        DataAdrM  = BASE + 8;
        #1;
        check("dec_sel_plus8", {31'b0, SelM}, 32'h0);
        check("dec_rd_plus8", ReadData, 32'h0);
        store(BASE + 8, 32'h55);
        DataAdrM  = BASE - 4;
        #1;
        check("dec_sel_minus4", {31'b0, SelM}, 32'h0);
        store(BASE - 4, 32'h55);
        repeat (45) step();
        read_check("dec_read6", BASE + 6, 32'h4);
        read_check("txdata_read", BASE + 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            r    = $urandom_range(0, 9);
            data = $urandom;
            if (r < 7)      addr = BASE + $urandom_range(0, 3);
            else if (r < 9) addr = BASE + 4 + $urandom_range(0, 3);
            else if (r[0])  addr = BASE + 8 * $urandom_range(1, 100);
            else            addr = BASE - 4 * $urandom_range(1, 100);
            store(addr, data);
            read_check("rand_status", BASE + 4, model_status(cyc));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 2);
            repeat (gap) step();
        end
        drain();
        read_check("rand_final", BASE + 4, model_status(cyc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
